// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Sequencer for the shared multi-cycle multiplier and divider
//                used by EX for mult/multu/div/divu. Latches one operation,
//                launches the right unit, stalls the pipeline until the result
//                is back and then issues a single HI/LO write pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, resetn              clock / asynchronous active-low reset
//    op_valid, op_type        operation request from EX (00 mult, 01 multu,
//                             10 div, 11 divu), held stable while stalled
//    src1, src2               rs / rt operands
//    flush                    kill the in-flight operation (no HI/LO write)
//    stallreq                 stall request to the stall controller
//    mul_signed/mul_a/mul_b   multiplier controls and operands
//    mul_result               multiplier result {hi,lo}
//    div_start/div_signed     divider start (level) and signed select
//    div_op1/div_op2          dividend / divisor
//    div_annul                one-cycle abort to the divider
//    div_ready/div_result     divider handshake, result {remainder,quotient}
//    hi_we/lo_we              HI/LO write strobes (one cycle)
//    hi_wdata/lo_wdata        HI/LO write data (holds between writes)
// ============================================================================
module muldiv_seq #(
    parameter int unsigned MUL_LAT     = 2,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stallreq,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    // One counter serves both the multiplier countdown and the divider
    // timeout, so it is sized for the larger of the two.
    localparam int CNT_W = $clog2(DIV_TIMEOUT + MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_type_q, op_type_d;
    logic [31:0]        src1_q, src1_d;
    logic [31:0]        src2_q, src2_d;
    logic [31:0]        hi_res_q, hi_res_d;
    logic [31:0]        lo_res_q, lo_res_d;

    logic               launch;
    logic               div_by_zero;
    logic               div_timeout;

    assign launch      = (state_q == IDLE) && op_valid && !flush;
    // Divide-by-zero is resolved locally without touching the divider.
    assign div_by_zero = op_type[1] && (src2 == 32'd0);
    assign div_timeout = (cnt_q == CNT_W'(DIV_TIMEOUT - 1));

    // ------------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_type_q <= 2'b00;
            src1_q    <= 32'd0;
            src2_q    <= 32'd0;
            hi_res_q  <= 32'd0;
            lo_res_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_type_q <= op_type_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            hi_res_q  <= hi_res_d;
            lo_res_q  <= lo_res_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_type_d = op_type_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        hi_res_d  = hi_res_q;
        lo_res_d  = lo_res_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    op_type_d = op_type;
                    src1_d    = src1;
                    src2_d    = src2;
                    if (!op_type[1]) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end else if (!div_by_zero) begin
                        state_d = DIV_BUSY;
                        cnt_d   = '0;
                    end else begin
                        state_d  = DONE;
                        hi_res_d = src1;
                        lo_res_d = 32'hFFFF_FFFF;
                    end
                end
            end

            MUL_WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = DONE;
                    hi_res_d = mul_result[63:32];
                    lo_res_d = mul_result[31:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DIV_BUSY: begin
                // flush beats a coincident div_ready; a result arriving on
                // the last allowed cycle still wins over the timeout.
                if (flush) begin
                    state_d = IDLE;
                end else if (div_ready) begin
                    state_d  = DONE;
                    hi_res_d = div_result[63:32];
                    lo_res_d = div_result[31:0];
                end else if (div_timeout) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        stallreq   = 1'b0;
        hi_we      = 1'b0;
        div_annul  = 1'b0;

        unique case (state_q)
            IDLE:     stallreq = launch && !div_by_zero;
            MUL_WAIT: stallreq = !flush;
            DIV_BUSY: begin
                stallreq  = !flush;
                div_annul = flush || (!div_ready && div_timeout);
            end
            DONE:     hi_we = !flush;
            default:  stallreq = 1'b0;
        endcase
    end

    assign lo_we      = hi_we;
    assign hi_wdata   = hi_res_q;
    assign lo_wdata   = lo_res_q;

    // Signed selects are qualified by state so every unit control is 0 at
    // reset and outside the unit's own phase.
    assign mul_signed = (state_q == MUL_WAIT) && !op_type_q[0];
    assign mul_a      = src1_q;
    assign mul_b      = src2_q;

    assign div_start  = (state_q == DIV_BUSY);
    assign div_signed = (state_q == DIV_BUSY) && (op_type_q == 2'b10);
    assign div_op1    = src1_q;
    assign div_op2    = src2_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Directed self-checking bench for muldiv_seq with a
//                behavioural multiplier and a delay-programmable divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stallreq;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(.MUL_LAT(2), .DIV_TIMEOUT(64)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op_type    (op_type),
        .src1       (src1),
        .src2       (src2),
        .flush      (flush),
        .stallreq   (stallreq),
        .mul_signed (mul_signed),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .div_annul  (div_annul),
        .div_ready  (div_ready),
        .div_result (div_result),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: result follows the operands.
    assign mul_result = mul_signed
        ? $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b})
        : {32'd0, mul_a} * {32'd0, mul_b};

    // Divider model: ready after div_delay cycles of div_start, result is a
    // hand-supplied constant.
    int          div_delay = 33;
    int          div_cnt   = 0;
    logic [63:0] div_value = 64'd0;
    assign div_ready  = div_start && (div_cnt == div_delay);
    assign div_result = div_value;

    always @(posedge clk) begin
        if (!div_start || div_ready) div_cnt <= 0;
        else                         div_cnt <= div_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last run_op
    int          r_stalls, r_hi_we, r_lo_we, r_dstart;
    logic [31:0] r_hi, r_lo;

    // Presents one operation and models EX: the instruction leaves on the
    // first edge where stallreq is low.
    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic left;
        left = 1'b0;
        r_stalls = 0; r_hi_we = 0; r_lo_we = 0; r_dstart = 0;
        r_hi = 32'd0; r_lo = 32'd0;
        @(negedge clk);
        op_valid = 1'b1; op_type = t; src1 = a; src2 = b;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!left && stallreq) r_stalls++;
            if (div_start) r_dstart++;
            if (lo_we) r_lo_we++;
            if (hi_we) begin
                r_hi_we++;
                r_hi = hi_wdata;
                r_lo = lo_wdata;
            end
            if (!left && !stallreq) left = 1'b1;
            @(negedge clk);
            if (left) op_valid = 1'b0;
        end
    endtask

    initial begin
        int annul_n, annul_at, we_n;
        resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00;
        src1 = 32'd0; src2 = 32'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              {32'd0, stallreq, mul_signed, div_start, div_signed, div_annul, hi_we, lo_we},
              64'd0);
        check("reset_data", {hi_wdata, lo_wdata}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // mult -2 * 3
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3);
        check("mult_stall", r_stalls, 3);
        check("mult_we", {r_hi_we[31:0], r_lo_we[31:0]}, {32'd1, 32'd1});
        check("mult_data", {r_hi, r_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // multu 0xFFFFFFFF * 2
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        check("multu_stall", r_stalls, 3);
        check("multu_we", {r_hi_we[31:0], r_lo_we[31:0]}, {32'd1, 32'd1});
        check("multu_data", {r_hi, r_lo}, 64'h0000_0001_FFFF_FFFE);

        // mult min*min: +2^62
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
        check("mult_min_data", {r_hi, r_lo}, 64'h4000_0000_0000_0000);

        // divu 100 / 7, ready after 33 cycles
        div_delay = 33; div_value = {32'd2, 32'd14};
        run_op(2'b11, 32'd100, 32'd7);
        check("divu_stall", r_stalls, 35);
        check("divu_dstart", r_dstart, 34);
        check("divu_we", {r_hi_we[31:0], r_lo_we[31:0]}, {32'd1, 32'd1});
        check("divu_data", {r_hi, r_lo}, {32'd2, 32'd14});

        // div 5 / 0
        run_op(2'b10, 32'd5, 32'd0);
        check("div0_stall", r_stalls, 0);
        check("div0_dstart", r_dstart, 0);
        check("div0_we", {r_hi_we[31:0], r_lo_we[31:0]}, {32'd1, 32'd1});
        check("div0_data", {r_hi, r_lo}, 64'h0000_0005_FFFF_FFFF);

        // div in flight, flush on cycle 10 together with div_ready
        div_delay = 9; div_value = {32'd2, 32'd6};
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b10; src1 = 32'd20; src2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_ready_seen", div_ready, 1'b1);
        check("flush_annul", div_annul, 1'b1);
        check("flush_stall", stallreq, 1'b0);
        check("flush_we", {hi_we, lo_we}, 2'b00);
        check("flush_dsigned", div_signed, 1'b1);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("flush_after", {div_start, div_annul, hi_we, stallreq}, 4'b0000);
        @(negedge clk);
        #1;
        check("flush_no_write", {hi_we, lo_we}, 2'b00);

        // divider never answers: timeout abort after 64 busy cycles
        div_delay = 1000;
        annul_n = 0; annul_at = -1; we_n = 0;
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b11; src1 = 32'd9; src2 = 32'd1;
        for (int i = 0; i < 90; i++) begin
            #1;
            if (div_annul) begin annul_n++; annul_at = i; end
            if (hi_we || lo_we) we_n++;
            @(negedge clk);
            if (annul_n != 0) op_valid = 1'b0;
        end
        check("timeout_annul_n", annul_n, 1);
        check("timeout_annul_at", annul_at, 64);
        check("timeout_we", we_n, 0);

        // reset in the middle of MUL_WAIT
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b01; src1 = 32'd7; src2 = 32'd9;
        @(negedge clk);
        #1;
        check("midrst_busy", stallreq, 1'b1);
        resetn = 1'b0; op_valid = 1'b0;
        #1;
        check("midrst_ctrl",
              {stallreq, mul_signed, div_start, div_signed, div_annul, hi_we, lo_we}, 7'd0);
        check("midrst_data", {mul_a, mul_b, hi_wdata, lo_wdata}, 128'd0);
        @(negedge clk);
        #1;
        check("midrst_no_write", {hi_we, lo_we}, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000);
        check("postrst_stall", r_stalls, 3);
        check("postrst_we", {r_hi_we[31:0], r_lo_we[31:0]}, {32'd1, 32'd1});
        check("postrst_data", {r_hi, r_lo}, 64'h0000_0001_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequences the shared multi-cycle multiplier and divider used by EX for mult/multu/div/divu.
- Accepts one operation from EX and launches the correct unit. Holds the pipeline via a stall request until the result is back, then issues one HI/LO write pulse.
- Sits between EX and the existing mul/div units, replacing the ad-hoc combinational divider control.

Parameters:
- MUL_LAT, 2, fixed multiplier latency in cycles from operand presentation to valid 64-bit result (legal range 1..15).
- DIV_TIMEOUT, 64, maximum cycles to wait for div_ready before forced abort.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  EX holds a mul/div instruction; held stable while stallreq=1
- op_type  in  2  00 mult, 01 multu, 10 div, 11 divu
- src1  in  32  rs operand
- src2  in  32  rt operand
- flush  in  1  kill the in-flight operation; no HI/LO write
- stallreq  out  1  stall request to the stall controller
- mul_signed  out  1  signed select to multiplier
- mul_a  out  32  multiplier operand A
- mul_b  out  32  multiplier operand B
- mul_result  in  64  multiplier result {hi,lo}
- div_start  out  1  divider start, held high while dividing
- div_signed  out  1  signed select to divider
- div_op1  out  32  dividend
- div_op2  out  32  divisor
- div_annul  out  1  one-cycle abort to divider
- div_ready  in  1  divider result valid
- div_result  in  64  divider result {remainder,quotient}
- hi_we  out  1  HI write strobe
- lo_we  out  1  LO write strobe
- hi_wdata  out  32  HI write data
- lo_wdata  out  32  LO write data

Behaviour:
- States: IDLE, MUL_WAIT, DIV_BUSY, DONE.
- Reset: async on resetn=0, state=IDLE, all registered outputs 0, counter 0.
- Operand latch: on IDLE with op_valid=1 and flush=0, latch op_type, src1 and src2 into internal registers. mul_* and div_op* are driven from the latched copies, so they stay stable for the whole operation.
- IDLE -> MUL_WAIT when op_type[1]=0. The counter loads MUL_LAT-1.
- IDLE -> DIV_BUSY when op_type[1]=1 and src2 != 0.
- IDLE -> DONE when op_type[1]=1 and src2 == 0. The divider is not started. Result is HI=src1, LO=32'hFFFFFFFF.
- MUL_WAIT: counter decrements each cycle. At 0, capture mul_result into the result regs and go to DONE.
  - Total stall is MUL_LAT+1 cycles.
- DIV_BUSY: div_start=1 and div_signed=(op_type==10). When div_ready=1, capture div_result and go to DONE.
  - If the timeout counter reaches DIV_TIMEOUT first, pulse div_annul, write nothing, and go to IDLE.
- DONE: hi_we=lo_we=1 for exactly one cycle, with hi_wdata/lo_wdata from the result regs. Then go to IDLE.
  - Strobes are 0 in every other state.
  - wdata holds its last value outside DONE.
- stallreq (combinational):
  - 1 when in IDLE with op_valid=1, flush=0 and the op is not divide-by-zero.
  - 1 in MUL_WAIT and DIV_BUSY.
  - 0 in DONE and otherwise.
  - Divide-by-zero stalls 0 cycles in IDLE, then writes in the following cycle while the instruction has already left EX.
- Retrigger guard: the instruction advances on the DONE-cycle edge. IDLE on the next cycle samples only a new op_valid, so the same instruction is never launched twice.
- flush in any state:
  - Next state is IDLE and the DONE strobes are suppressed.
  - div_annul is pulsed for one cycle if the state was DIV_BUSY.
  - stallreq goes to 0 in the same cycle.
  - flush has priority over a simultaneous div_ready or counter expiry.
- Signedness: mult/div use two's complement and multu/divu are unsigned. Divider quotient sign and remainder sign follow the divider unit's own rules; no post-correction here.
- Reset mid-operation: immediate return to IDLE. div_start drops asynchronously. No write.

Test Plan:
- mult src1=32'hFFFFFFFE (-2), src2=3, MUL_LAT=2 → stallreq high 3 cycles, then DONE pulse with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- multu src1=32'hFFFFFFFF, src2=2 → hi=1, lo=32'hFFFFFFFE; exactly one hi_we/lo_we pulse.
- divu src1=100, src2=7, divider model ready after 33 cycles → div_start high throughout, stallreq drops the cycle after div_ready, hi=2, lo=14.
- div src1=5, src2=0 → no div_start, stallreq never asserted, next cycle hi=5, lo=32'hFFFFFFFF.
- div in flight, flush asserted at cycle 10 coincident with div_ready → div_annul pulse, no hi_we, state IDLE, stallreq 0 that cycle.
- resetn pulled low mid-MUL_WAIT → all outputs 0 immediately, then a fresh multu completes correctly after release.
